fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width of PC and cache request address.
REQ-002 Parameter WORD_WIDTH, 32, instruction word width.
REQ-003 Parameter FIFO_DEPTH, 4, prefetch queue entries (power of two, >=2).
REQ-004 Parameter RESET_PC, 32'h00000000, first fetch address after reset.
REQ-005 HCLK  in  1  the only clock; all state changes on rising edge.
REQ-006 HRESETn  in  1  one clock; reset is asynchronous and active-low.
REQ-007 ic_req  out  1  instruction-cache request, held high until ic_valid.
REQ-008 ic_addr  out  ADDR_WIDTH  request address, stable while ic_req high.
REQ-009 ic_valid  in  1  single-cycle response strobe, only in a cycle after an ic_req-high cycle.
REQ-010 ic_data  in  WORD_WIDTH  instruction word, qualified by ic_valid.
REQ-011 redirect  in  1  branch/exception redirect strobe from execute.
REQ-012 redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored, treated as 0.
REQ-013 inst_valid  out  1  queue head holds a valid instruction.
REQ-014 inst_data  out  WORD_WIDTH  queue head instruction.
REQ-015 inst_pc  out  ADDR_WIDTH  address of queue head instruction.
REQ-016 inst_ready  in  1  decode accepts head; transfer when inst_valid && inst_ready.
REQ-017 fifo_count  out  log2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-018 State machine states IDLE, REQ, DISCARD; registers pc (next fetch), req_addr, queue of {pc,data}.
REQ-019 IDLE: ic_req=0; if no redirect and fifo_count<FIFO_DEPTH, req_addr<=pc, next state REQ.
REQ-020 REQ: ic_req=1, ic_addr=req_addr; without ic_valid and without redirect, stay REQ.
REQ-021 REQ with ic_valid, no redirect: push {req_addr, ic_data}, pc<=req_addr+4 modulo 2^ADDR_WIDTH; next REQ with req_addr<=req_addr+4 if post-edge occupancy<FIFO_DEPTH, else IDLE.
REQ-022 REQ with redirect, no ic_valid: flush queue, pc<=redirect_pc, next DISCARD (ic_req and ic_addr unchanged).
REQ-023 REQ with redirect and ic_valid same cycle: response dropped, flush queue, pc<=redirect_pc, next IDLE.
REQ-024 DISCARD: ic_req=1, ic_addr=req_addr; on ic_valid drop data, next IDLE; redirect in DISCARD updates pc only.
REQ-025 IDLE with redirect: flush queue, pc<=redirect_pc, stay IDLE one cycle.
REQ-026 Redirect takes priority over pop; a decode handshake in a redirect cycle is ignored and queue is empty after the edge.
REQ-027 Pop on inst_valid && inst_ready advances head; push and pop in same cycle leave count unchanged.
REQ-028 No bypass: a word accepted at edge N is visible on inst_* after edge N (one-cycle latency ic_valid -> inst_valid).
REQ-029 Push only occurs with free space (guaranteed by REQ-019/021); overflow never occurs, underflow pop ignored.
REQ-030 inst_valid = (fifo_count!=0); inst_data/inst_pc driven from head entry registers.
REQ-031 Fetch address wrap: 0xFFFFFFFC + 4 -> 0x00000000, no flag.

Reset
REQ-032 HRESETn low asynchronously: state IDLE, pc=RESET_PC, req_addr=RESET_PC, queue empty, fifo_count=0.
REQ-033 During reset ic_req=0, ic_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
REQ-034 Reset mid-REQ abandons the outstanding request; first ic_req high in the first cycle after the first edge following deassertion.

Verification
REQ-035 Reset release, ic_valid 2 cycles after each req, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8 with matching ic_data, no gaps in order.
REQ-036 inst_ready=0, responses immediate -> 4 pushes, fifo_count=4, ic_req=0 in IDLE; one pop -> next request for 0x10.
REQ-037 Redirect to 0x100 while waiting on request 0x8 -> DISCARD, late response for 0x8 never reaches inst_*, next ic_addr=0x100.
REQ-038 Redirect to 0x200 coinciding with ic_valid and inst_ready -> queue empty next cycle, next fetch 0x200, dropped word absent.
REQ-039 redirect_pc=0xFFFFFFFE -> fetch 0xFFFFFFFC then 0x00000000.
REQ-040 HRESETn low mid-REQ with 3 queued -> inst_valid=0 and ic_req=0 immediately (asynchronously), restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with one outstanding cache request and a small prefetch queue.
// Redirects flush the queue and squash any in-flight cache response.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    WORD_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    output logic                        ic_req,
    output logic [ADDR_WIDTH-1:0]       ic_addr,
    input  logic                        ic_valid,
    input  logic [WORD_WIDTH-1:0]       ic_data,
    input  logic                        redirect,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        inst_valid,
    output logic [WORD_WIDTH-1:0]       inst_data,
    output logic [ADDR_WIDTH-1:0]       inst_pc,
    input  logic                        inst_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

    entry_t                queue_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q, count_post;
    logic                  push, pop, flush, full;

    assign next_addr           = req_addr_q + ADDR_WIDTH'(4);
    assign redirect_pc_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    // redirect wins over a decode handshake in the same cycle
    assign pop        = inst_valid && inst_ready && !redirect;
    assign count_post = count_q + CNT_W'(1) - CNT_W'(pop);

    assign ic_req     = (state_q != IDLE);
    assign ic_addr    = req_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = queue_q[head_q].data;
    assign inst_pc    = queue_q[head_q].pc;
    assign fifo_count = count_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = redirect;
        if (redirect) pc_d = redirect_pc_aligned;
        case (state_q)
            IDLE: begin
                if (!redirect && !full) begin
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // a response coinciding with the redirect is simply dropped
                    state_d = ic_valid ? IDLE : DISCARD;
                end else if (ic_valid) begin
                    push = 1'b1;
                    pc_d = next_addr;
                    if (count_post < CNT_W'(FIFO_DEPTH)) req_addr_d = next_addr;
                    else                                  state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (ic_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) queue_q[i] <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                queue_q[tail_q] <= {req_addr_q, ic_data};
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
